// File: rtl/decode_stage.sv
// Decode stage: captures an instruction word and its NPC, and registers the
// execute / writeback / memory control fields decoded from the opcode.
// Optional feature: define DECODE_ILLEGAL_OP_EN to add the registered
// illegal_op output flagging the unassigned opcodes.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_control,
  output logic [1:0]  W_control,
  output logic        Mem_control,
`ifdef DECODE_ILLEGAL_OP_EN
  output logic        illegal_op,
`endif
  output logic        decode_valid
);

  // Opcode encodings (dout[15:12]).
  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  // ALU function select.
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluAnd = 2'b01;
  localparam logic [1:0] AluNot = 2'b10;

  // Address offset select for the PC/address adder.
  localparam logic [1:0] PcSelNone = 2'b00;
  localparam logic [1:0] PcSelOff9 = 2'b01;
  localparam logic [1:0] PcSelOff6 = 2'b10;
  localparam logic [1:0] PcSelZero = 2'b11;

  // Writeback source select.
  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbPc  = 2'b01;
  localparam logic [1:0] WbMem = 2'b10;

  logic [3:0] opcode;
  logic       imm_mode;

  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] w_sel;
  logic       mem_ind;
  logic       illegal;

  assign opcode   = dout[15:12];
  // Bit 5 selects the immediate form of ADD/AND.
  assign imm_mode = dout[5];

  // Combinational decode of the incoming instruction word.
  always_comb begin
    alu_control = AluAdd;
    pcselect1   = PcSelNone;
    pcselect2   = 1'b0;
    op2select   = 1'b0;
    w_sel       = WbAlu;
    mem_ind     = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OpAdd: begin
        alu_control = AluAdd;
        op2select   = ~imm_mode;
        w_sel       = WbAlu;
      end
      OpAnd: begin
        alu_control = AluAnd;
        op2select   = ~imm_mode;
        w_sel       = WbAlu;
      end
      OpNot: begin
        alu_control = AluNot;
        op2select   = 1'b1;
        w_sel       = WbAlu;
      end
      OpBr: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
      end
      OpJmp: begin
        pcselect1 = PcSelZero;
        pcselect2 = 1'b0;
      end
      OpLd: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
        w_sel     = WbMem;
      end
      OpLdi: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
        w_sel     = WbMem;
        mem_ind   = 1'b1;
      end
      OpLdr: begin
        pcselect1 = PcSelOff6;
        pcselect2 = 1'b0;
        w_sel     = WbMem;
      end
      OpLea: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
        w_sel     = WbPc;
      end
      OpSt: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
      end
      OpSti: begin
        pcselect1 = PcSelOff9;
        pcselect2 = 1'b1;
        mem_ind   = 1'b1;
      end
      OpStr: begin
        pcselect1 = PcSelOff6;
        pcselect2 = 1'b0;
      end
      // 0100, 1000, 1101, 1111: all-zero control, IR still captured.
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Pipeline register: reset clears, enable captures, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_control    <= '0;
      W_control    <= '0;
      Mem_control  <= 1'b0;
      decode_valid <= 1'b0;
    end else begin
      decode_valid <= enable_decode;
      if (enable_decode) begin
        IR          <= dout;
        npc_out     <= npc_in;
        E_control   <= {alu_control, pcselect1, pcselect2, op2select};
        W_control   <= w_sel;
        Mem_control <= mem_ind;
      end
    end
  end

`ifdef DECODE_ILLEGAL_OP_EN
  // Illegal-opcode flag follows the same capture/hold/reset rules.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else if (enable_decode) begin
      illegal_op <= illegal;
    end
  end
`else
  // Decoded flag has no consumer in this build.
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule
